// File: rtl/frame_sel_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// frame_sel_ctrl_pkg
//
// Shared definitions for the frame-select controller:
//   - state_t      : controller state encodings (S_PAUSE / S_RUN / S_WAIT)
//   - OVR_CNT_W    : width of the overrun event counter
//   - CH_*         : channel indices into the input synchroniser bank
//   - is_pow2()    : elaboration-time helper used to choose shift vs multiply
//                    for the frame base address
// -----------------------------------------------------------------------------
package frame_sel_ctrl_pkg;

    typedef enum logic [1:0] {
        S_PAUSE = 2'd0,
        S_RUN   = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    // Overrun counter width; the counter saturates at its all-ones value.
    localparam int OVR_CNT_W = 8;

    // Synchroniser bank channel assignment.
    localparam int NUM_SYNC_CH = 3;
    localparam int CH_TICK     = 0;
    localparam int CH_STEP     = 1;
    localparam int CH_RUN      = 2;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
//
// Two-flop synchroniser followed by an edge register for rising-edge detect.
// The input is sampled on edge 1, becomes the synchronised level after edge 2,
// and the rise pulse is high for exactly one cycle between edges 2 and 3.
//
// Ports:
//   clk      in   sampling clock
//   rst      in   asynchronous reset, active-high (all flops cleared)
//   async_in in   asynchronous level input
//   sync_lvl out  synchronised level
//   rise     out  one-cycle pulse on a 0->1 transition of sync_lvl
// -----------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_lvl,
    output logic rise
);

    logic meta_reg;
    logic sync_reg;
    logic edge_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            meta_reg <= async_in;
            sync_reg <= meta_reg;
            edge_reg <= sync_reg;
        end
    end

    assign sync_lvl = sync_reg;
    // Because the flops clear to 0, an input held high through reset release
    // produces one rise pulse once it reaches sync_reg.
    assign rise     = sync_reg & ~edge_reg;

endmodule

// File: rtl/frame_sel_ctrl.sv
// -----------------------------------------------------------------------------
// frame_sel_ctrl
//
// Consumer of the slow (2 Hz) frame tick. The tick, the step button and the
// run/pause switch are resynchronised into the clk_in domain. Each accepted
// event advances a circular frame index; the matching base address is offered
// to the frame reader with a req/ack handshake.
//
// States:
//   S_PAUSE : paused=1; run_en high -> S_RUN (wins over a step); step -> advance
//   S_RUN   : paused=0; tick -> advance (wins over run_en low); run_en low -> S_PAUSE
//   S_WAIT  : frame_req=1, index/base frozen, paused holds its source value;
//             frame_ack returns to S_RUN/S_PAUSE according to run_en
//
// Optional feature, macro FRAME_SEL_OVERRUN_EN:
//   defined   -> overrun_cnt counts events dropped in S_WAIT (saturating at 255,
//                cleared only by rst)
//   undefined -> overrun_cnt is tied to 0; events in S_WAIT are still dropped
//
// Ports:
//   clk_in        in   50 MHz system clock
//   rst           in   asynchronous reset, active-high
//   frame_tick_in in   slow frame clock, asynchronous
//   run_en        in   1 = auto-advance, 0 = paused, asynchronous
//   step_req      in   debounced step button level, asynchronous
//   frame_ack     in   reader has latched frame_base
//   frame_req     out  frame_base valid, held until acknowledged
//   frame_idx     out  current frame index
//   frame_base    out  frame_idx * FRAME_LEN
//   paused        out  1 while paused (held through S_WAIT)
//   overrun_cnt   out  dropped advance events
// -----------------------------------------------------------------------------
module frame_sel_ctrl
    import frame_sel_ctrl_pkg::*;
#(
    parameter int NUM_FRAMES  = 8,
    parameter int FRAME_IDX_W = 3,
    parameter int FRAME_LEN   = 512,
    parameter int ADDR_W      = 12
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   frame_tick_in,
    input  logic                   run_en,
    input  logic                   step_req,
    input  logic                   frame_ack,
    output logic                   frame_req,
    output logic [FRAME_IDX_W-1:0] frame_idx,
    output logic [ADDR_W-1:0]      frame_base,
    output logic                   paused,
    output logic [OVR_CNT_W-1:0]   overrun_cnt
);

    localparam bit LEN_IS_POW2 = is_pow2(FRAME_LEN);
    localparam int LEN_SHIFT   = $clog2(FRAME_LEN);

    // -------------------------------------------------------------------------
    // Input conditioning
    // -------------------------------------------------------------------------
    logic [NUM_SYNC_CH-1:0] async_vec;
    logic [NUM_SYNC_CH-1:0] sync_lvl;
    logic [NUM_SYNC_CH-1:0] sync_rise;

    assign async_vec[CH_TICK] = frame_tick_in;
    assign async_vec[CH_STEP] = step_req;
    assign async_vec[CH_RUN]  = run_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SYNC_CH; gi++) begin : g_sync
            sync_edge_det u_sync (
                .clk      (clk_in),
                .rst      (rst),
                .async_in (async_vec[gi]),
                .sync_lvl (sync_lvl[gi]),
                .rise     (sync_rise[gi])
            );
        end
    endgenerate

    logic tick_rise;
    logic step_rise;
    logic run_en_s;

    assign tick_rise = sync_rise[CH_TICK];
    assign step_rise = sync_rise[CH_STEP];
    assign run_en_s  = sync_lvl[CH_RUN];

    // Tick/step are edge-driven and run_en is level-driven; the remaining
    // synchroniser outputs are intentionally left unused.
    logic unused_sync;
    assign unused_sync = &{1'b0, sync_lvl[CH_TICK], sync_lvl[CH_STEP], sync_rise[CH_RUN]};

    // -------------------------------------------------------------------------
    // Controller registers
    // -------------------------------------------------------------------------
    state_t                 state_reg,  state_next;
    logic [FRAME_IDX_W-1:0] idx_reg,    idx_next;
    logic [ADDR_W-1:0]      base_reg,   base_next;
    logic                   req_reg,    req_next;
    logic                   paused_reg, paused_next;

    // Candidate index/base for an advance, computed from the current index.
    logic [FRAME_IDX_W-1:0] idx_adv;
    logic [ADDR_W-1:0]      base_adv;

    assign idx_adv = (idx_reg == FRAME_IDX_W'(NUM_FRAMES - 1)) ? '0
                                                               : idx_reg + FRAME_IDX_W'(1);

    generate
        if (LEN_IS_POW2) begin : g_base_shift
            assign base_adv = ADDR_W'(idx_adv) << LEN_SHIFT;
        end else begin : g_base_mult
            assign base_adv = ADDR_W'(32'(idx_adv) * 32'(FRAME_LEN));
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg  <= S_PAUSE;
            idx_reg    <= '0;
            base_reg   <= '0;
            req_reg    <= 1'b0;
            paused_reg <= 1'b1;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            base_reg   <= base_next;
            req_reg    <= req_next;
            paused_reg <= paused_next;
        end
    end

    always_comb begin
        logic advance;

        state_next  = state_reg;
        idx_next    = idx_reg;
        base_next   = base_reg;
        req_next    = req_reg;
        paused_next = paused_reg;
        advance     = 1'b0;

        case (state_reg)
            S_PAUSE: begin
                paused_next = 1'b1;
                req_next    = 1'b0;
                // Leaving pause wins over a simultaneous step press.
                if (run_en_s) begin
                    state_next  = S_RUN;
                    paused_next = 1'b0;
                end else if (step_rise) begin
                    advance    = 1'b1;
                    state_next = S_WAIT;
                end
            end

            S_RUN: begin
                paused_next = 1'b0;
                req_next    = 1'b0;
                // A tick arriving with the switch falling still advances;
                // the pause is taken when the handshake completes.
                if (tick_rise) begin
                    advance    = 1'b1;
                    state_next = S_WAIT;
                end else if (!run_en_s) begin
                    state_next  = S_PAUSE;
                    paused_next = 1'b1;
                end
            end

            S_WAIT: begin
                req_next = 1'b1;
                if (frame_ack) begin
                    req_next = 1'b0;
                    if (run_en_s) begin
                        state_next  = S_RUN;
                        paused_next = 1'b0;
                    end else begin
                        state_next  = S_PAUSE;
                        paused_next = 1'b1;
                    end
                end
            end

            default: begin
                // Unused encoding: recover to a safe idle state.
                state_next  = S_PAUSE;
                paused_next = 1'b1;
                req_next    = 1'b0;
            end
        endcase

        if (advance) begin
            idx_next  = idx_adv;
            base_next = base_adv;
            req_next  = 1'b1;
        end
    end

    assign frame_req  = req_reg;
    assign frame_idx  = idx_reg;
    assign frame_base = base_reg;
    assign paused     = paused_reg;

    // -------------------------------------------------------------------------
    // Overrun counter
    // -------------------------------------------------------------------------
`ifdef FRAME_SEL_OVERRUN_EN
    logic [OVR_CNT_W-1:0] ovr_reg, ovr_next;
    logic                 drop_evt;

    // Only the event relevant to the mode we came from counts: ticks while
    // running, step presses while paused.
    assign drop_evt = (state_reg == S_WAIT) && (paused_reg ? step_rise : tick_rise);

    always_comb begin
        ovr_next = ovr_reg;
        if (drop_evt && (ovr_reg != '1)) begin
            ovr_next = ovr_reg + OVR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            ovr_reg <= '0;
        end else begin
            ovr_reg <= ovr_next;
        end
    end

    assign overrun_cnt = ovr_reg;
`else
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_sel_ctrl
//
// Directed bench for frame_sel_ctrl. Each advance event pushes the expected
// index/base onto a scoreboard queue; the entry is popped and compared when
// frame_req rises. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_frame_sel_ctrl;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick_in = 1'b0;
    logic        run_en = 1'b1;
    logic        step_req = 1'b0;
    logic        frame_ack = 1'b0;
    logic        frame_req;
    logic [2:0]  frame_idx;
    logic [11:0] frame_base;
    logic        paused;
    logic [7:0]  overrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int model_idx = 0;

    typedef struct packed {
        logic [2:0]  idx;
        logic [11:0] base;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_exp;

`ifdef FRAME_SEL_OVERRUN_EN
    localparam int EXP_OVR = 3;
`else
    localparam int EXP_OVR = 0;
`endif

    frame_sel_ctrl #(
        .NUM_FRAMES  (8),
        .FRAME_IDX_W (3),
        .FRAME_LEN   (512),
        .ADDR_W      (12)
    ) dut (
        .clk_in        (clk_in),
        .rst           (rst),
        .frame_tick_in (frame_tick_in),
        .run_en        (run_en),
        .step_req      (step_req),
        .frame_ack     (frame_ack),
        .frame_req     (frame_req),
        .frame_idx     (frame_idx),
        .frame_base    (frame_base),
        .paused        (paused),
        .overrun_cnt   (overrun_cnt)
    );

    always #10 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Reference model: circular index over 8 frames of 512 words.
    task automatic push_expected();
        exp_t e;
        model_idx = (model_idx == 7) ? 0 : model_idx + 1;
        e.idx  = 3'(model_idx);
        e.base = 12'(model_idx * 512);
        sb_q.push_back(e);
    endtask

    // Called right after the stimulus edge is driven (on a falling edge).
    // Expects frame_req on the 3rd rising edge, then checks the scoreboard.
    task automatic wait_req(input string tag);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (frame_req !== 1'b1 && cyc < 12);
        check({tag, "_latency"}, 32'(cyc), 32'd3);
        if (sb_q.size() != 0) begin
            last_exp = sb_q.pop_front();
            check({tag, "_idx"},  32'(frame_idx),  32'(last_exp.idx));
            check({tag, "_base"}, 32'(frame_base), 32'(last_exp.base));
            $display("txn %s idx=%0d base=%0d req=%0d paused=%0d", tag, frame_idx, frame_base,
                     frame_req, paused);
        end
    endtask

    task automatic do_ack(input string tag);
        frame_ack = 1'b1;
        @(negedge clk_in);
        frame_ack = 1'b0;
        check({tag, "_req_drop"}, 32'(frame_req), 32'd0);
    endtask

    task automatic advance_and_check(input string tag, input bit use_step, input bit drop_run,
                                     input bit exp_paused_wait, input bit exp_paused_after);
        push_expected();
        if (use_step) step_req = 1'b1;
        else          frame_tick_in = 1'b1;
        if (drop_run) run_en = 1'b0;
        wait_req(tag);
        check({tag, "_paused_wait"}, 32'(paused), 32'(exp_paused_wait));
        repeat (2) @(negedge clk_in);
        check({tag, "_req_held"}, 32'(frame_req), 32'd1);
        check({tag, "_idx_held"}, 32'(frame_idx), 32'(last_exp.idx));
        do_ack(tag);
        check({tag, "_paused_after"}, 32'(paused), 32'(exp_paused_after));
        frame_tick_in = 1'b0;
        step_req      = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    initial begin
        // ---------------- Reset with run_en high ----------------
        repeat (3) @(negedge clk_in);
        check("rst_paused", 32'(paused), 32'd1);
        check("rst_idx", 32'(frame_idx), 32'd0);
        check("rst_base", 32'(frame_base), 32'd0);
        check("rst_req", 32'(frame_req), 32'd0);
        check("rst_ovr", 32'(overrun_cnt), 32'd0);
        $display("txn reset idx=%0d paused=%0d", frame_idx, paused);
        rst = 1'b0;
        repeat (2) @(negedge clk_in);
        check("rel_paused_e2", 32'(paused), 32'd1);
        @(negedge clk_in);
        check("rel_paused_e3", 32'(paused), 32'd0);

        // ---------------- Run mode, 9 ticks with wrap ----------------
        for (int k = 0; k < 9; k++) begin
            advance_and_check($sformatf("run%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // ---------------- Pause: ticks ignored, steps advance ----------------
        run_en = 1'b0;
        repeat (4) @(negedge clk_in);
        check("pause_enter", 32'(paused), 32'd1);
        for (int k = 0; k < 3; k++) begin
            frame_tick_in = 1'b1;
            repeat (6) @(negedge clk_in);
            check($sformatf("pause_tick%0d_req", k), 32'(frame_req), 32'd0);
            check($sformatf("pause_tick%0d_idx", k), 32'(frame_idx), 32'(model_idx));
            $display("txn pause_tick%0d idx=%0d req=%0d", k, frame_idx, frame_req);
            frame_tick_in = 1'b0;
            repeat (4) @(negedge clk_in);
        end
        advance_and_check("step0", 1'b1, 1'b0, 1'b1, 1'b1);
        advance_and_check("step1", 1'b1, 1'b0, 1'b1, 1'b1);

        // ---------------- Overrun: ticks while ack withheld ----------------
        run_en = 1'b1;
        repeat (4) @(negedge clk_in);
        check("resume_paused", 32'(paused), 32'd0);
        push_expected();
        frame_tick_in = 1'b1;
        wait_req("ovr");
        for (int b = 0; b < 3; b++) begin
            frame_tick_in = 1'b0;
            repeat (4) @(negedge clk_in);
            frame_tick_in = 1'b1;
            repeat (4) @(negedge clk_in);
        end
        check("ovr_idx_held", 32'(frame_idx), 32'(last_exp.idx));
        check("ovr_req_held", 32'(frame_req), 32'd1);
        check("ovr_cnt", 32'(overrun_cnt), 32'(EXP_OVR));
        $display("txn overrun idx=%0d ovr=%0d", frame_idx, overrun_cnt);
        do_ack("ovr");
        check("ovr_cnt_after", 32'(overrun_cnt), 32'(EXP_OVR));
        frame_tick_in = 1'b0;
        repeat (4) @(negedge clk_in);

        // ---------------- Tick and run_en fall together ----------------
        advance_and_check("simul", 1'b0, 1'b1, 1'b0, 1'b1);

        // ---------------- Reset in the middle of a handshake ----------------
        push_expected();
        step_req = 1'b1;
        wait_req("rstmid");
        rst = 1'b1;
        #1;
        check("rstmid_req", 32'(frame_req), 32'd0);
        check("rstmid_idx", 32'(frame_idx), 32'd0);
        check("rstmid_base", 32'(frame_base), 32'd0);
        check("rstmid_ovr", 32'(overrun_cnt), 32'd0);
        check("rstmid_paused", 32'(paused), 32'd1);
        $display("txn reset_mid idx=%0d req=%0d", frame_idx, frame_req);
        step_req  = 1'b0;
        model_idx = 0;
        @(negedge clk_in);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
